// File: rtl/game_stage_sequencer_if.sv
// Control/status bundle between the top level and the stage sequencer.
// The master drives game events and the slave reports enables, resets and game status.
interface game_stage_sequencer_if #(
  parameter int STAGE_W = 3,
  parameter int LIVES_W = 2
);
  logic               start_game;
  logic               pause;
  logic               skip_stage;
  logic               startOfFrame;
  logic               win_stage;
  logic               player_dead;
  logic               enable_player;
  logic               enable_monst;
  logic               enable_boss;
  logic               enable_astero;
  logic               resetN_player;
  logic               resetN_monst;
  logic [STAGE_W-1:0] stage_num;
  logic [LIVES_W-1:0] lives_left;
  logic               paused;
  logic               game_over;
  logic               game_won;

  modport master (
    output start_game, pause, skip_stage, startOfFrame, win_stage, player_dead,
    input  enable_player, enable_monst, enable_boss, enable_astero,
           resetN_player, resetN_monst, stage_num, lives_left,
           paused, game_over, game_won
  );

  modport slave (
    input  start_game, pause, skip_stage, startOfFrame, win_stage, player_dead,
    output enable_player, enable_monst, enable_boss, enable_astero,
           resetN_player, resetN_monst, stage_num, lives_left,
           paused, game_over, game_won
  );
endinterface

// File: rtl/game_stage_sequencer.sv
// Game flow sequencer: stages, lives, intro/respawn frame delays, pause and cheat-skip.
// Enables and local object resets are registered off the next state, so they line up with state_q.
module game_stage_sequencer #(
  parameter int                    NUM_STAGES     = 4,
  parameter int                    STAGE_W        = 3,
  parameter int                    NUM_LIVES      = 3,
  parameter int                    LIVES_W        = 2,
  parameter int                    INTRO_FRAMES   = 120,
  parameter int                    RESPAWN_FRAMES = 60,
  parameter int                    FRAME_W        = 8,
  parameter logic [NUM_STAGES-1:0] BOSS_MASK      = 4'b1000,
  parameter logic [NUM_STAGES-1:0] ASTERO_MASK    = 4'b0100
) (
  input logic                    clk,
  input logic                    rst,
  game_stage_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INTRO, S_PLAY, S_PAUSE, S_RESPAWN, S_CLEAR, S_OVER, S_WON
  } state_t;

  typedef struct packed {
    logic en_player;
    logic en_monst;
    logic en_boss;
    logic en_astero;
    logic rstn_player;
    logic rstn_monst;
    logic paused;
    logic over;
    logic won;
  } flags_t;

  localparam int                 MASK_W     = 1 << STAGE_W;
  localparam logic [MASK_W-1:0]  BOSS_EXT   = MASK_W'(BOSS_MASK);
  localparam logic [MASK_W-1:0]  ASTERO_EXT = MASK_W'(ASTERO_MASK);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [FRAME_W-1:0] INTRO_LAST = FRAME_W'(INTRO_FRAMES - 1);
  localparam logic [FRAME_W-1:0] RESP_LAST  = FRAME_W'(RESPAWN_FRAMES - 1);

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               start_q, skip_q;
  flags_t             flags_q, flags_d;
  logic               start_ev, skip_ev;
  logic [FRAME_W-1:0] frame_last;

  // Edge registers reset high so a level held through reset never fires an event.
  assign start_ev   = bus.start_game & ~start_q;
  assign skip_ev    = bus.skip_stage & ~skip_q;
  assign frame_last = (state_q == S_INTRO) ? INTRO_LAST : RESP_LAST;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    lives_d = lives_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: if (start_ev) begin
        state_d = S_INTRO;
        stage_d = '0;
        lives_d = LIVES_INIT;
        frame_d = '0;
      end
      S_INTRO, S_RESPAWN: begin
        if (skip_ev) state_d = S_CLEAR;
        else if (bus.startOfFrame) begin
          if (frame_q == frame_last) begin
            state_d = S_PLAY;
            frame_d = '0;
          end else frame_d = frame_q + FRAME_W'(1);
        end
      end
      S_PLAY: begin
        if (skip_ev || bus.win_stage) state_d = S_CLEAR;
        else if (bus.player_dead) begin
          lives_d = (lives_q != '0) ? lives_q - LIVES_W'(1) : '0;
          state_d = (lives_q <= LIVES_W'(1)) ? S_OVER : S_RESPAWN;
          frame_d = '0;
        end else if (bus.pause) state_d = S_PAUSE;
      end
      S_PAUSE: if (!bus.pause) state_d = S_PLAY;
      S_CLEAR: begin
        frame_d = '0;
        if (stage_q >= LAST_STAGE) state_d = S_WON;
        else begin
          stage_d = stage_q + STAGE_W'(1);
          state_d = S_INTRO;
        end
      end
      S_OVER, S_WON: if (start_ev) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // IDLE, INTRO and CLEAR hold both object resets asserted with everything disabled.
  always_comb begin
    flags_d = '0;
    case (state_d)
      S_PLAY: begin
        flags_d.en_player   = 1'b1;
        flags_d.en_monst    = 1'b1;
        flags_d.en_boss     = BOSS_EXT[stage_d];
        flags_d.en_astero   = ASTERO_EXT[stage_d];
        flags_d.rstn_player = 1'b1;
        flags_d.rstn_monst  = 1'b1;
      end
      S_PAUSE: begin
        flags_d.rstn_player = 1'b1;
        flags_d.rstn_monst  = 1'b1;
        flags_d.paused      = 1'b1;
      end
      S_RESPAWN: flags_d.rstn_monst = 1'b1;
      S_OVER: begin
        flags_d.rstn_player = 1'b1;
        flags_d.rstn_monst  = 1'b1;
        flags_d.over        = 1'b1;
      end
      S_WON: begin
        flags_d.rstn_player = 1'b1;
        flags_d.rstn_monst  = 1'b1;
        flags_d.won         = 1'b1;
      end
      default: flags_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      lives_q <= LIVES_INIT;
      frame_q <= '0;
      start_q <= 1'b1;
      skip_q  <= 1'b1;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      lives_q <= lives_d;
      frame_q <= frame_d;
      start_q <= bus.start_game;
      skip_q  <= bus.skip_stage;
      flags_q <= flags_d;
    end
  end

  assign bus.enable_player = flags_q.en_player;
  assign bus.enable_monst  = flags_q.en_monst;
  assign bus.enable_boss   = flags_q.en_boss;
  assign bus.enable_astero = flags_q.en_astero;
  assign bus.resetN_player = flags_q.rstn_player;
  assign bus.resetN_monst  = flags_q.rstn_monst;
  assign bus.paused        = flags_q.paused;
  assign bus.game_over     = flags_q.over;
  assign bus.game_won      = flags_q.won;
  assign bus.stage_num     = stage_q;
  assign bus.lives_left    = lives_q;

endmodule

// File: tb/tb_game_stage_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change (with its cycle);
// a negedge monitor pops and compares whenever the output bundle changes.
module tb_game_stage_sequencer;
  localparam int INTRO_F = 3;
  localparam int RESP_F  = 2;
  localparam logic [3:0] BOSS   = 4'b1000;
  localparam logic [3:0] ASTERO = 4'b0100;
  localparam int S_IDLE = 0, S_INTRO = 1, S_PLAY = 2, S_PAUSE = 3,
                 S_RESP = 4, S_CLEAR = 5, S_OVER = 6, S_WON = 7;

  typedef struct packed {
    logic       ep, em, eb, ea, rp, rm;
    logic [2:0] stage;
    logic [1:0] lives;
    logic       paused, over, won;
  } snap_t;

  typedef struct {
    snap_t s;
    int    at;
    string tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  q[$];
  snap_t prev;
  bit    first = 1'b1;

  game_stage_sequencer_if #(.STAGE_W(3), .LIVES_W(2)) bus ();

  game_stage_sequencer #(
    .NUM_STAGES(4), .STAGE_W(3), .NUM_LIVES(3), .LIVES_W(2),
    .INTRO_FRAMES(INTRO_F), .RESPAWN_FRAMES(RESP_F), .FRAME_W(8),
    .BOSS_MASK(4'b1000), .ASTERO_MASK(4'b0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t snap(int st, int stg, int lv);
    snap_t s;
    logic [2:0] sv;
    s = '0;
    sv = 3'(stg);
    s.stage = sv;
    s.lives = 2'(lv);
    case (st)
      S_PLAY:  begin s.ep = 1; s.em = 1; s.eb = BOSS[sv[1:0]]; s.ea = ASTERO[sv[1:0]];
                     s.rp = 1; s.rm = 1; end
      S_PAUSE: begin s.rp = 1; s.rm = 1; s.paused = 1; end
      S_RESP:  s.rm = 1;
      S_OVER:  begin s.rp = 1; s.rm = 1; s.over = 1; end
      S_WON:   begin s.rp = 1; s.rm = 1; s.won = 1; end
      default: ;
    endcase
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.ep = bus.enable_player;  s.em = bus.enable_monst;
    s.eb = bus.enable_boss;    s.ea = bus.enable_astero;
    s.rp = bus.resetN_player;  s.rm = bus.resetN_monst;
    s.stage = bus.stage_num;   s.lives = bus.lives_left;
    s.paused = bus.paused;     s.over = bus.game_over;  s.won = bus.game_won;
    return s;
  endfunction

  // Monitor: every change of the output bundle is one transaction.
  always @(negedge clk) begin
    snap_t cur;
    exp_t  e;
    cur = dut_snap();
    if (first || cur != prev) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change got=%h cyc=%0d required=no change", cur, cyc);
      end else begin
        e = q.pop_front();
        if (cur !== e.s || (e.at >= 0 && e.at != cyc)) begin
          n_bad++;
          $display("FAIL %s got=%h at cyc %0d required=%h at cyc %0d",
                   e.tag, cur, cyc, e.s, e.at);
        end
      end
    end
    prev  = cur;
    first = 1'b0;
  end

  task automatic push_at(snap_t s, int at, string tag);
    exp_t e;
    e.s = s; e.at = at; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic frame();
    bus.startOfFrame = 1'b1; tick();
    bus.startOfFrame = 1'b0; repeat (3) tick();
  endtask

  task automatic last_frame(snap_t s, string tag);
    bus.startOfFrame = 1'b1;
    push_at(s, cyc + 1, tag);
    tick();
    bus.startOfFrame = 1'b0; repeat (3) tick();
  endtask

  task automatic play_after_intro(int stg, int lv);
    repeat (INTRO_F - 1) frame();
    last_frame(snap(S_PLAY, stg, lv), "intro_to_play");
  endtask

  task automatic play_after_respawn(int stg, int lv);
    repeat (RESP_F - 1) frame();
    last_frame(snap(S_PLAY, stg, lv), "respawn_to_play");
  endtask

  task automatic start_pulse(bit expect_change, snap_t s, string tag);
    bus.start_game = 1'b1;
    if (expect_change) push_at(s, cyc + 1, tag);
    tick();
    bus.start_game = 1'b0; tick();
  endtask

  task automatic win(int stg, int lv, bit last, bit with_death);
    bus.win_stage = 1'b1;
    bus.player_dead = with_death;
    push_at(snap(S_CLEAR, stg, lv), cyc + 1, "play_to_clear");
    if (last) push_at(snap(S_WON, stg, lv), cyc + 2, "clear_to_won");
    else      push_at(snap(S_INTRO, stg + 1, lv), cyc + 2, "clear_to_intro");
    tick(); tick();
    bus.win_stage = 1'b0; bus.player_dead = 1'b0; tick();
  endtask

  task automatic die(int stg, int lv_after, bit to_over);
    bus.player_dead = 1'b1;
    push_at(snap(to_over ? S_OVER : S_RESP, stg, lv_after), cyc + 1,
            to_over ? "death_to_over" : "death_to_respawn");
    tick();
    bus.player_dead = 1'b0; tick();
  endtask

  initial begin
    bus.start_game = 0; bus.pause = 0; bus.skip_stage = 0;
    bus.startOfFrame = 0; bus.win_stage = 0; bus.player_dead = 0;
    push_at(snap(S_IDLE, 0, 3), -1, "reset_state");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Start, intro, then walk every stage to a win.
    start_pulse(1'b0, '0, "");
    play_after_intro(0, 3);
    for (int s = 0; s < 3; s++) begin
      win(s, 3, 1'b0, 1'b0);
      play_after_intro(s + 1, 3);
    end
    win(3, 3, 1'b1, 1'b0);
    start_pulse(1'b1, snap(S_IDLE, 3, 3), "won_to_idle");
    start_pulse(1'b1, snap(S_INTRO, 0, 3), "idle_to_intro");

    // Lives, then win beating a same-cycle death at lives=1, then game over.
    play_after_intro(0, 3);
    die(0, 2, 1'b0);
    play_after_respawn(0, 2);
    die(0, 1, 1'b0);
    play_after_respawn(0, 1);
    win(0, 1, 1'b0, 1'b1);
    play_after_intro(1, 1);
    die(1, 0, 1'b1);
    start_pulse(1'b1, snap(S_IDLE, 1, 0), "over_to_idle");
    start_pulse(1'b1, snap(S_INTRO, 0, 3), "idle_to_intro2");

    // Pause with skip held high throughout: no stage change.
    play_after_intro(0, 3);
    bus.pause = 1'b1;
    push_at(snap(S_PAUSE, 0, 3), cyc + 1, "play_to_pause");
    tick();
    bus.skip_stage = 1'b1;
    repeat (100) frame();
    bus.pause = 1'b0;
    push_at(snap(S_PLAY, 0, 3), cyc + 1, "pause_to_play");
    tick();
    repeat (3) frame();
    bus.skip_stage = 1'b0; tick();

    // Skip held 50 clks in PLAY advances exactly once.
    bus.skip_stage = 1'b1;
    push_at(snap(S_CLEAR, 0, 3), cyc + 1, "skip_play_to_clear");
    push_at(snap(S_INTRO, 1, 3), cyc + 2, "skip_clear_to_intro");
    repeat (50) tick();
    bus.skip_stage = 1'b0; tick();

    // Skip during INTRO goes through CLEAR to the next stage.
    bus.skip_stage = 1'b1;
    push_at(snap(S_INTRO, 2, 3), cyc + 2, "skip_in_intro");
    tick(); tick();
    bus.skip_stage = 1'b0; tick();
    play_after_intro(2, 3);

    // Reset in the middle of a respawn.
    die(2, 2, 1'b0);
    frame();
    push_at(snap(S_IDLE, 0, 3), -1, "reset_mid_respawn");
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_expectations got=%0d required=0 next=%s", q.size(), q[0].tag);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
